// File: rtl/micro_sequencer.sv
// Writable-control-store microprogram sequencer: loadable microcode and opcode dispatch map,
// conditional branches, micro-call/return stack, memory-wait stall and IDLE/RUN/HALTED control.
module micro_sequencer #(
    parameter int IR_W        = 16,
    parameter int OPC_W       = 8,
    parameter int UADDR_W     = 5,
    parameter int CTRL_W      = 35,
    parameter int NFLAGS      = 2,
    parameter int STACK_DEPTH = 2,
    parameter int RESET_UADDR = 0,
    localparam int CSEL_W     = ($clog2(NFLAGS) > 1) ? $clog2(NFLAGS) : 1,
    localparam int UW         = CTRL_W + UADDR_W + 3 + CSEL_W + 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [IR_W-1:0]    ir,
    input  logic [NFLAGS-1:0]  flags,
    input  logic               mem_ready,
    input  logic               cs_we,
    input  logic [UADDR_W-1:0] cs_addr,
    input  logic [UW-1:0]      cs_wdata,
    input  logic               map_we,
    input  logic [OPC_W-1:0]   map_addr,
    input  logic [UADDR_W-1:0] map_wdata,
    output logic [CTRL_W-1:0]  ctrl,
    output logic [UADDR_W-1:0] upc,
    output logic               br,
    output logic               running,
    output logic               halted,
    output logic               err
);

    localparam int SP_W = $clog2(STACK_DEPTH + 1);
    localparam logic [UADDR_W-1:0] RESET_ADDR = UADDR_W'(RESET_UADDR);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HALTED
    } state_e;

    typedef enum logic [2:0] {
        OP_NEXT,
        OP_JUMP,
        OP_BRANCH,
        OP_DISPATCH,
        OP_CALL,
        OP_RET,
        OP_HALT,
        OP_RSVD
    } seq_op_e;

    // Field order mirrors the microword layout, MSB first.
    typedef struct packed {
        logic                wait_mem;
        logic                cond_pol;
        logic [CSEL_W-1:0]   cond_sel;
        seq_op_e             seq_op;
        logic [UADDR_W-1:0]  nxt;
        logic [CTRL_W-1:0]   ctrl;
    } uword_t;

    logic [UW-1:0]      cs_mem  [2**UADDR_W];
    logic [UADDR_W-1:0] map_mem [2**OPC_W];
    logic [UADDR_W-1:0] stack_q [STACK_DEPTH];
    logic [UADDR_W-1:0] stack_d [STACK_DEPTH];

    state_e             state_q, state_d;
    logic [UADDR_W-1:0] upc_q, upc_d;
    uword_t             uir_q, uir_d;
    logic [SP_W-1:0]    sp_q, sp_d;
    logic               err_q, err_d;

    logic [OPC_W-1:0]   opcode;
    logic               loads_ok;
    logic               cond_flag;
    logic               cond_taken;
    logic [UADDR_W-1:0] stack_top;
    logic [UADDR_W-1:0] upc_inc;
    logic               stall;
    logic               advance;
    logic [UADDR_W-1:0] next_addr;
    logic               fetch;

    assign opcode   = ir[IR_W-1 -: OPC_W];
    assign loads_ok = (state_q != ST_RUN);
    assign upc_inc  = upc_q + UADDR_W'(1);

    generate
        if (IR_W > OPC_W) begin : g_ir_lsbs
            logic unused_ir_lsbs;
            assign unused_ir_lsbs = ^ir[IR_W-OPC_W-1:0];
        end
    endgenerate

    // NOTE: storage arrays (control store, map, return stack) carry no reset; only the
    // sequencing state is reset, and sp=0 makes stale stack entries unreachable.
    always_ff @(posedge clk) begin
        if (cs_we && loads_ok) begin
            cs_mem[cs_addr] <= cs_wdata;
        end
        if (map_we && loads_ok) begin
            map_mem[map_addr] <= map_wdata;
        end
        stack_q <= stack_d;
    end

    // Out-of-range cond_sel values read as a zero flag.
    always_comb begin
        cond_flag = 1'b0;
        for (int i = 0; i < NFLAGS; i++) begin
            if (uir_q.cond_sel == CSEL_W'(i)) begin
                cond_flag = flags[i];
            end
        end
        cond_taken = cond_flag ^ uir_q.cond_pol;
    end

    always_comb begin
        stack_top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (sp_q == SP_W'(i + 1)) begin
                stack_top = stack_q[i];
            end
        end
    end

    assign stall   = (state_q == ST_RUN) && uir_q.wait_mem && !mem_ready;
    assign advance = (state_q == ST_RUN) && !stall;

    // NOTE: combinational next-state logic uses blocking assignments with every target
    // defaulted first, so no latches are inferred; the state registers below use <= only.
    always_comb begin
        state_d   = state_q;
        upc_d     = upc_q;
        uir_d     = uir_q;
        sp_d      = sp_q;
        err_d     = err_q;
        stack_d   = stack_q;
        next_addr = upc_inc;
        fetch     = 1'b0;

        case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (start) begin
                    state_d = ST_RUN;
                    upc_d   = RESET_ADDR;
                    uir_d   = uword_t'(cs_mem[RESET_ADDR]);
                    sp_d    = '0;
                    err_d   = 1'b0;
                end
            end
            ST_RUN: begin
                if (advance) begin
                    fetch = 1'b1;
                    case (uir_q.seq_op)
                        OP_JUMP:     next_addr = uir_q.nxt;
                        OP_BRANCH:   if (cond_taken) next_addr = uir_q.nxt;
                        OP_DISPATCH: next_addr = map_mem[opcode];
                        OP_CALL: begin
                            if (sp_q == SP_W'(STACK_DEPTH)) begin
                                state_d = ST_HALTED;
                                err_d   = 1'b1;
                                fetch   = 1'b0;
                            end else begin
                                for (int i = 0; i < STACK_DEPTH; i++) begin
                                    if (sp_q == SP_W'(i)) begin
                                        stack_d[i] = upc_inc;
                                    end
                                end
                                sp_d      = sp_q + SP_W'(1);
                                next_addr = uir_q.nxt;
                            end
                        end
                        OP_RET: begin
                            if (sp_q == '0) begin
                                state_d = ST_HALTED;
                                err_d   = 1'b1;
                                fetch   = 1'b0;
                            end else begin
                                sp_d      = sp_q - SP_W'(1);
                                next_addr = stack_top;
                            end
                        end
                        OP_HALT: begin
                            state_d = ST_HALTED;
                            fetch   = 1'b0;
                        end
                        default: next_addr = upc_inc;
                    endcase
                    if (fetch) begin
                        upc_d = next_addr;
                        uir_d = uword_t'(cs_mem[next_addr]);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            upc_q   <= RESET_ADDR;
            uir_q   <= '0;
            sp_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            upc_q   <= upc_d;
            uir_q   <= uir_d;
            sp_q    <= sp_d;
            err_q   <= err_d;
        end
    end

    assign ctrl    = (state_q == ST_RUN) ? uir_q.ctrl : '0;
    assign upc     = upc_q;
    assign running = (state_q == ST_RUN);
    assign halted  = (state_q == ST_HALTED);
    assign err     = err_q;

    always_comb begin
        br = 1'b0;
        if (advance) begin
            case (uir_q.seq_op)
                OP_JUMP, OP_DISPATCH, OP_CALL, OP_RET: br = 1'b1;
                OP_BRANCH:                             br = cond_taken;
                default:                               br = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_micro_sequencer.sv
// Scoreboard bench for micro_sequencer: a cycle-level program-execution model predicts the
// outputs of every cycle; a negedge monitor pops and compares them against the DUT.
module tb_micro_sequencer;

    localparam int IR_W        = 16;
    localparam int OPC_W       = 8;
    localparam int UADDR_W     = 5;
    localparam int CTRL_W      = 35;
    localparam int NFLAGS      = 2;
    localparam int STACK_DEPTH = 2;
    localparam int RESET_UADDR = 0;
    localparam int CSEL_W      = 1;
    localparam int UW          = CTRL_W + UADDR_W + 3 + CSEL_W + 2;
    localparam int CS_DEPTH    = 1 << UADDR_W;
    localparam int MAP_DEPTH   = 1 << OPC_W;

    localparam int OP_NEXT = 0, OP_JUMP = 1, OP_BRANCH = 2, OP_DISPATCH = 3;
    localparam int OP_CALL = 4, OP_RET = 5, OP_HALT = 6;
    localparam int S_IDLE = 0, S_RUN = 1, S_HALTED = 2;

    logic               clk;
    logic               rst;
    logic               start;
    logic [IR_W-1:0]    ir;
    logic [NFLAGS-1:0]  flags;
    logic               mem_ready;
    logic               cs_we;
    logic [UADDR_W-1:0] cs_addr;
    logic [UW-1:0]      cs_wdata;
    logic               map_we;
    logic [OPC_W-1:0]   map_addr;
    logic [UADDR_W-1:0] map_wdata;
    logic [CTRL_W-1:0]  ctrl;
    logic [UADDR_W-1:0] upc;
    logic               br;
    logic               running;
    logic               halted;
    logic               err;

    micro_sequencer #(
        .IR_W(IR_W), .OPC_W(OPC_W), .UADDR_W(UADDR_W), .CTRL_W(CTRL_W),
        .NFLAGS(NFLAGS), .STACK_DEPTH(STACK_DEPTH), .RESET_UADDR(RESET_UADDR)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .ir(ir), .flags(flags), .mem_ready(mem_ready),
        .cs_we(cs_we), .cs_addr(cs_addr), .cs_wdata(cs_wdata),
        .map_we(map_we), .map_addr(map_addr), .map_wdata(map_wdata),
        .ctrl(ctrl), .upc(upc), .br(br), .running(running), .halted(halted), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [CTRL_W-1:0]  ctrl;
        logic [UADDR_W-1:0] upc;
        logic               br;
        logic               running;
        logic               halted;
        logic               err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle_no = 0;

    // Reference model: what the program is doing, expressed as plain arithmetic and queues.
    logic [UW-1:0] m_cs  [CS_DEPTH];
    int            m_map [MAP_DEPTH];
    int            m_state;
    int            m_upc;
    logic [UW-1:0] m_uw;
    int            m_stack[$];
    bit            m_err;

    task automatic model_reset();
        m_state = S_IDLE;
        m_upc   = RESET_UADDR;
        m_uw    = '0;
        m_stack.delete();
        m_err   = 1'b0;
    endtask

    function automatic logic [UW-1:0] mkw(input int op, input int nxt, input logic [CTRL_W-1:0] c,
                                          input int sel, input int pol, input int wt);
        logic [UW-1:0] w;
        w = '0;
        w[CTRL_W-1:0]                      = c;
        w[CTRL_W +: UADDR_W]               = UADDR_W'(nxt);
        w[CTRL_W+UADDR_W +: 3]             = 3'(op);
        w[CTRL_W+UADDR_W+3 +: CSEL_W]      = CSEL_W'(sel);
        w[UW-2]                            = 1'(pol);
        w[UW-1]                            = 1'(wt);
        return w;
    endfunction

    function automatic logic [UW-1:0] rnd_word();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[UW-1:0];
    endfunction

    // One clock cycle: predict this cycle's outputs, advance the model across the edge.
    task automatic tick();
        exp_t e;
        int   op, nxt, sel, nu;
        bit   pol, wt, fl, taken, stall, fetch;
        if (rst) model_reset();
        nxt   = int'(m_uw[CTRL_W +: UADDR_W]);
        op    = int'(m_uw[CTRL_W+UADDR_W +: 3]);
        sel   = int'(m_uw[CTRL_W+UADDR_W+3 +: CSEL_W]);
        pol   = m_uw[UW-2];
        wt    = m_uw[UW-1];
        fl    = (sel < NFLAGS) ? flags[sel] : 1'b0;
        taken = fl ^ pol;
        stall = (m_state == S_RUN) && wt && !mem_ready;

        e.ctrl    = (m_state == S_RUN) ? m_uw[CTRL_W-1:0] : '0;
        e.upc     = UADDR_W'(m_upc);
        e.br      = (m_state == S_RUN) && !stall &&
                    (op == OP_JUMP || op == OP_DISPATCH || op == OP_CALL || op == OP_RET ||
                     (op == OP_BRANCH && taken));
        e.running = (m_state == S_RUN);
        e.halted  = (m_state == S_HALTED);
        e.err     = m_err;
        exp_q.push_back(e);

        if (!rst) begin
            if (m_state != S_RUN) begin
                if (start) begin
                    m_state = S_RUN;
                    m_upc   = RESET_UADDR;
                    m_uw    = m_cs[RESET_UADDR];
                    m_stack.delete();
                    m_err   = 1'b0;
                end
                if (cs_we)  m_cs[cs_addr]    = cs_wdata;
                if (map_we) m_map[map_addr]  = int'(map_wdata);
            end else if (!stall) begin
                fetch = 1'b1;
                nu    = (m_upc + 1) % CS_DEPTH;
                case (op)
                    OP_JUMP:     nu = nxt;
                    OP_BRANCH:   if (taken) nu = nxt;
                    OP_DISPATCH: nu = m_map[ir[IR_W-1 -: OPC_W]];
                    OP_CALL: begin
                        if (m_stack.size() == STACK_DEPTH) begin
                            m_state = S_HALTED; m_err = 1'b1; fetch = 1'b0;
                        end else begin
                            m_stack.push_back((m_upc + 1) % CS_DEPTH);
                            nu = nxt;
                        end
                    end
                    OP_RET: begin
                        if (m_stack.size() == 0) begin
                            m_state = S_HALTED; m_err = 1'b1; fetch = 1'b0;
                        end else begin
                            nu = m_stack.pop_back();
                        end
                    end
                    OP_HALT: begin
                        m_state = S_HALTED; fetch = 1'b0;
                    end
                    default: ;
                endcase
                if (fetch) begin
                    m_upc = nu;
                    m_uw  = m_cs[nu];
                end
            end
        end

        @(posedge clk);
        #1;
        start  = 1'b0;
        cs_we  = 1'b0;
        map_we = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic load_cs(input int a, input logic [UW-1:0] w);
        cs_we = 1'b1; cs_addr = UADDR_W'(a); cs_wdata = w;
        tick();
    endtask

    task automatic load_map(input int a, input int t);
        map_we = 1'b1; map_addr = OPC_W'(a); map_wdata = UADDR_W'(t);
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
    endtask

    // Monitor: the DUT presents a full output set every cycle; compare at the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            cycle_no++;
            if (ctrl !== e.ctrl || upc !== e.upc || br !== e.br || running !== e.running ||
                halted !== e.halted || err !== e.err) begin
                errors++;
                $display("FAIL cycle %0d outputs: got ctrl=%h upc=%0d br=%b running=%b halted=%b err=%b, expected ctrl=%h upc=%0d br=%b running=%b halted=%b err=%b",
                         cycle_no, ctrl, upc, br, running, halted, err,
                         e.ctrl, e.upc, e.br, e.running, e.halted, e.err);
            end
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; ir = '0; flags = '0; mem_ready = 1'b1;
        cs_we = 1'b0; cs_addr = '0; cs_wdata = '0;
        map_we = 1'b0; map_addr = '0; map_wdata = '0;
        model_reset();
        @(posedge clk);
        #1;
        reset_pulse();

        for (int a = 0; a < CS_DEPTH; a++)  load_cs(a, rnd_word());
        for (int a = 0; a < MAP_DEPTH; a++) load_map(a, int'($urandom_range(0, CS_DEPTH - 1)));

        // Straight-line program with a jump and a halt.
        reset_pulse();
        load_cs(0, mkw(OP_NEXT, 0, 35'h1, 0, 0, 0));
        load_cs(1, mkw(OP_JUMP, 5, 35'h2, 0, 0, 0));
        load_cs(5, mkw(OP_HALT, 0, 35'h0, 0, 0, 0));
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            flags = NFLAGS'($urandom()); ir = IR_W'($urandom());
            tick();
        end

        // Conditional branch on Z under both polarities and flag values.
        reset_pulse();
        load_cs(0, mkw(OP_NEXT, 0, 35'h10, 0, 0, 0));
        load_cs(1, mkw(OP_NEXT, 0, 35'h11, 0, 0, 0));
        load_cs(3, mkw(OP_HALT, 0, 35'h13, 0, 0, 0));
        load_cs(9, mkw(OP_HALT, 0, 35'h19, 0, 0, 0));
        for (int pol = 0; pol < 2; pol++) begin
            for (int z = 0; z < 2; z++) begin
                load_cs(2, mkw(OP_BRANCH, 9, 35'h12, 0, pol, 0));
                flags = {1'($urandom()), 1'(z)};
                pulse_start();
                run(6);
            end
        end

        // Dispatch through the map; a map write during RUN must be ignored.
        reset_pulse();
        load_map(8'hA3, 17);
        load_map(8'h5B, 3);
        load_cs(0,  mkw(OP_DISPATCH, 0, 35'h20, 0, 0, 0));
        load_cs(17, mkw(OP_NEXT, 0, 35'h40, 0, 0, 0));
        load_cs(18, mkw(OP_DISPATCH, 0, 35'h41, 0, 0, 0));
        load_cs(3,  mkw(OP_HALT, 0, 35'h42, 0, 0, 0));
        ir = 16'hA3C4;
        pulse_start();
        tick();
        map_we = 1'b1; map_addr = 8'hA3; map_wdata = 5'd3;
        tick();
        tick();
        tick();
        ir = 16'h5B01;
        run(5);

        // Memory-wait stall, then reset asserted in the middle of a stall.
        reset_pulse();
        load_cs(0, mkw(OP_NEXT, 0, 35'h4, 0, 0, 1));
        load_cs(1, mkw(OP_HALT, 0, 35'h7, 0, 0, 0));
        mem_ready = 1'b0;
        pulse_start();
        run(3);
        mem_ready = 1'b1;
        run(4);
        mem_ready = 1'b0;
        pulse_start();
        run(2);
        reset_pulse();
        run(2);
        mem_ready = 1'b1;
        pulse_start();
        run(4);

        // Nested calls, then overflow, then underflow.
        reset_pulse();
        load_cs(0, mkw(OP_CALL, 4, 35'h1, 0, 0, 0));
        load_cs(4, mkw(OP_CALL, 8, 35'h2, 0, 0, 0));
        load_cs(8, mkw(OP_RET, 0, 35'h3, 0, 0, 0));
        load_cs(5, mkw(OP_RET, 0, 35'h5, 0, 0, 0));
        load_cs(1, mkw(OP_HALT, 0, 35'h6, 0, 0, 0));
        pulse_start();
        run(8);
        load_cs(8, mkw(OP_CALL, 12, 35'h8, 0, 0, 0));
        load_cs(12, mkw(OP_HALT, 0, 35'hC, 0, 0, 0));
        pulse_start();
        run(6);
        load_cs(0, mkw(OP_RET, 0, 35'h9, 0, 0, 0));
        pulse_start();
        run(3);

        // Random microprograms with random flags, ir, stalls, restarts and loads.
        reset_pulse();
        for (int a = 0; a < CS_DEPTH; a++) load_cs(a, rnd_word());
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 3) == 0) reset_pulse();
            pulse_start();
            for (int c = 0; c < int'($urandom_range(5, 30)); c++) begin
                ir        = IR_W'($urandom());
                flags     = NFLAGS'($urandom());
                mem_ready = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 7) == 0) start = 1'b1;
                if ($urandom_range(0, 5) == 0) begin
                    cs_we = 1'b1; cs_addr = UADDR_W'($urandom()); cs_wdata = rnd_word();
                end
                if ($urandom_range(0, 7) == 0) begin
                    map_we = 1'b1; map_addr = OPC_W'($urandom()); map_wdata = UADDR_W'($urandom());
                end
                tick();
            end
        end

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected cycles never compared, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
